// File: rtl/fpga_cfg_pkg.sv
// Shared fixed-point configuration for the LSM datapath.
// Holds the Q-format widths and the common saturation helper.
package fpga_cfg_pkg;

    localparam int FP_WIDTH = 32;
    localparam int FP_QINT  = 15;
    localparam int FP_QFRAC = 16;

    // Clamp a sign-extended wide value into a signed w-bit range.
    function automatic logic signed [127:0] saturate(
        input logic signed [127:0] v,
        input int unsigned         w
    );
        logic signed [127:0] hi;
        logic signed [127:0] lo;
        hi = (128'sd1 <<< (w - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/fx_div.sv
// Signed fixed-point divider: restoring, one quotient bit per cycle,
// valid/ready on both sides, saturated WIDTH-bit quotient.
module fx_div
    import fpga_cfg_pkg::*;
#(
    parameter int WIDTH = FP_WIDTH,
    parameter int QINT  = FP_QINT,
    parameter int QFRAC = FP_QFRAC,
    parameter int NUM_W = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    output logic                    ready_out,
    input  logic signed [NUM_W-1:0] numerator,
    input  logic signed [WIDTH-1:0] denominator,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic signed [WIDTH-1:0] result,
    output logic                    div_by_zero
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} fxdiv_state_t;

    localparam int CW = $clog2(NUM_W + 1);

    if (QINT + QFRAC + 1 != WIDTH) begin : g_fmt_check
        $error("fx_div: QINT + QFRAC + 1 must equal WIDTH");
    end

    fxdiv_state_t     state;
    logic [WIDTH:0]   rem;
    logic [NUM_W-1:0] num_r;
    logic [NUM_W:0]   quot;
    logic [WIDTH-1:0] dvs;
    logic             sign_q;
    logic             num_neg;
    logic             dz;
    logic [CW-1:0]    cnt;

    logic [NUM_W:0]          mag;
    logic [WIDTH-1:0]        dabs;
    logic [WIDTH+1:0]        rem_sh;
    logic [WIDTH+1:0]        rem_nx;
    logic                    ge;
    logic signed [NUM_W+1:0] qs;
    logic signed [127:0]     wide;

    assign ready_out = (state == IDLE);

    always_comb begin
        mag = numerator[NUM_W-1] ? -{numerator[NUM_W-1], numerator}
                                 : {1'b0, numerator};
        dabs = denominator[WIDTH-1] ? -denominator : denominator;
        rem_sh = {rem, num_r[NUM_W-1]};
        ge = rem_sh >= {2'b00, dvs};
        rem_nx = ge ? rem_sh - {2'b00, dvs} : rem_sh;
        qs = $signed({1'b0, quot});
        if (sign_q)
            qs = -qs;
        wide = {{(128 - NUM_W - 2){qs[NUM_W+1]}}, qs};
        // A zero divisor forces full-scale with the numerator's sign.
        if (dz)
            wide = num_neg ? {1'b1, {127{1'b0}}} : {1'b0, {127{1'b1}}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rem         <= '0;
            num_r       <= '0;
            quot        <= '0;
            dvs         <= '0;
            sign_q      <= 1'b0;
            num_neg     <= 1'b0;
            dz          <= 1'b0;
            cnt         <= '0;
            valid_out   <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (valid_in) begin
                        // Magnitude MSB preloads the remainder; it is
                        // always below a non-zero divisor.
                        rem     <= {{WIDTH{1'b0}}, mag[NUM_W]};
                        num_r   <= mag[NUM_W-1:0];
                        quot    <= '0;
                        dvs     <= dabs;
                        sign_q  <= numerator[NUM_W-1] ^ denominator[WIDTH-1];
                        num_neg <= numerator[NUM_W-1];
                        dz      <= (denominator == '0);
                        cnt     <= CW'(NUM_W);
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        rem   <= (WIDTH + 1)'(rem_nx);
                        num_r <= {num_r[NUM_W-2:0], 1'b0};
                        quot  <= {quot[NUM_W-1:0], ge};
                        cnt   <= cnt - 1'b1;
                    end else begin
                        result      <= WIDTH'(saturate(wide, WIDTH));
                        div_by_zero <= dz;
                        valid_out   <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (ready_in) begin
                        valid_out <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fx_div.sv
// Directed self-checking bench for fx_div.
// Each task drives one scenario and compares against hand-computed values.
module tb_fx_div;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               valid_in = 1'b0;
    logic               ready_out;
    logic signed [63:0] numerator = '0;
    logic signed [31:0] denominator = '0;
    logic               valid_out;
    logic               ready_in = 1'b0;
    logic signed [31:0] result;
    logic               div_by_zero;

    int pass_cnt = 0;
    int total = 0;

    localparam logic [31:0] MAXP = 32'h7FFF_FFFF;
    localparam logic [31:0] MAXN = 32'h8000_0000;

    always #5 clk = ~clk;

    fx_div dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .numerator  (numerator),
        .denominator(denominator),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .result     (result),
        .div_by_zero(div_by_zero)
    );

    // Issue one division and wait (bounded) for valid_out.
    task automatic start_wait(
        input  logic signed [63:0] n,
        input  logic signed [31:0] d,
        output logic [31:0]        r,
        output logic               z,
        output int                 lat,
        output logic               ro_hi
    );
        @(negedge clk);
        numerator = n;
        denominator = d;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        lat = 0;
        ro_hi = ready_out;
        while (!valid_out && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (ready_out) ro_hi = 1'b1;
        end
        r = result;
        z = div_by_zero;
    endtask

    task automatic release_result();
        @(negedge clk);
        ready_in = 1'b1;
        @(posedge clk);
        #1;
        ready_in = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (ready_out !== 1'b1)
            $display("FAIL reset_ready got %b want 1", ready_out);
        else pass_cnt++;
        total++;
        if (valid_out !== 1'b0)
            $display("FAIL reset_valid got %b want 0", valid_out);
        else pass_cnt++;
        total++;
        if (result !== 32'd0 || div_by_zero !== 1'b0)
            $display("FAIL reset_result got %h/%b want 0/0", result, div_by_zero);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] r;
        logic z;
        logic ro;
        int lat;
        start_wait(64'sd100, 32'sd7, r, z, lat, ro);
        total++;
        if (r !== 32'd14 || z !== 1'b0)
            $display("FAIL basic_100_7 got %h/%b want 0000000e/0", r, z);
        else pass_cnt++;
        total++;
        if (lat !== 65)
            $display("FAIL basic_latency got %0d want 65", lat);
        else pass_cnt++;
        total++;
        if (ro !== 1'b0)
            $display("FAIL basic_ready_busy got %b want 0", ro);
        else pass_cnt++;
        release_result();
        total++;
        if (ready_out !== 1'b1 || valid_out !== 1'b0)
            $display("FAIL basic_return got rdy=%b vld=%b want 1/0",
                     ready_out, valid_out);
        else pass_cnt++;
    endtask

    task automatic test_signs();
        logic signed [63:0] n [4] = '{-64'sd100, 64'sd100, -64'sd100, -64'sd7};
        logic signed [31:0] d [4] = '{32'sd7, -32'sd7, -32'sd7, 32'sd100};
        logic [31:0] e [4] = '{32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'd14, 32'd0};
        logic [31:0] r;
        logic z;
        logic ro;
        int lat;
        for (int i = 0; i < 4; i++) begin
            start_wait(n[i], d[i], r, z, lat, ro);
            total++;
            if (r !== e[i] || z !== 1'b0)
                $display("FAIL sign_%0d got %h/%b want %h/0", i, r, z, e[i]);
            else pass_cnt++;
            release_result();
        end
    endtask

    task automatic test_saturation();
        logic signed [63:0] n [4];
        logic signed [31:0] d [4] = '{32'sd1, 32'sd1, -32'sd1, 32'sd1};
        logic [31:0] e [4] = '{MAXP, MAXN, MAXP, MAXN};
        logic [31:0] r;
        logic z;
        logic ro;
        int lat;
        n[0] = 64'sd1 <<< 40;
        n[1] = -(64'sd1 <<< 40);
        n[2] = 64'h8000_0000_0000_0000;
        n[3] = -(64'sd1 <<< 31);
        for (int i = 0; i < 4; i++) begin
            start_wait(n[i], d[i], r, z, lat, ro);
            total++;
            if (r !== e[i] || z !== 1'b0)
                $display("FAIL sat_%0d got %h/%b want %h/0", i, r, z, e[i]);
            else pass_cnt++;
            release_result();
        end
    endtask

    task automatic test_zero_div();
        logic signed [63:0] n [2] = '{64'sd5, -64'sd5};
        logic [31:0] e [2] = '{MAXP, MAXN};
        logic [31:0] r;
        logic z;
        logic ro;
        int lat;
        for (int i = 0; i < 2; i++) begin
            start_wait(n[i], 32'sd0, r, z, lat, ro);
            total++;
            if (r !== e[i] || z !== 1'b1)
                $display("FAIL dz_%0d got %h/%b want %h/1", i, r, z, e[i]);
            else pass_cnt++;
            total++;
            if (lat !== 65)
                $display("FAIL dz_latency_%0d got %0d want 65", i, lat);
            else pass_cnt++;
            release_result();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r;
        logic z;
        logic ro;
        logic bad;
        int lat;
        @(negedge clk);
        numerator = 64'sd1000;
        denominator = -32'sd3;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        while (!valid_out && lat < 200) begin
            @(negedge clk);
            valid_in = ~valid_in;
            numerator = 64'sd77 + 64'(lat);
            denominator = 32'sd2;
            @(posedge clk);
            #1;
            lat++;
        end
        total++;
        if (result !== 32'hFFFF_FEB3 || lat !== 65)
            $display("FAIL bp_result got %h lat %0d want fffffeb3 lat 65",
                     result, lat);
        else pass_cnt++;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            valid_in = ~valid_in;
            numerator = -64'sd9;
            @(posedge clk);
            #1;
            if (valid_out !== 1'b1 || result !== 32'hFFFF_FEB3 ||
                div_by_zero !== 1'b0 || ready_out !== 1'b0)
                bad = 1'b1;
        end
        total++;
        if (bad !== 1'b0)
            $display("FAIL bp_hold got vld=%b res=%h rdy=%b want 1/fffffeb3/0",
                     valid_out, result, ready_out);
        else pass_cnt++;
        @(negedge clk);
        ready_in = 1'b1;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (valid_out !== 1'b0 || ready_out !== 1'b1)
            $display("FAIL bp_release got vld=%b rdy=%b want 0/1",
                     valid_out, ready_out);
        else pass_cnt++;
        ready_in = 1'b0;
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (ready_out !== 1'b1)
            $display("FAIL bp_no_accept_in_done got rdy=%b want 1", ready_out);
        else pass_cnt++;
        start_wait(64'sd1966080 <<< 16, 32'sd10, r, z, lat, ro);
        total++;
        if (r !== MAXP || z !== 1'b0)
            $display("FAIL bp_next_sat got %h/%b want 7fffffff/0", r, z);
        else pass_cnt++;
        release_result();
    endtask

    task automatic test_reset_mid_busy();
        logic [31:0] r;
        logic z;
        logic ro;
        int lat;
        @(negedge clk);
        numerator = 64'sd100;
        denominator = 32'sd7;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (valid_out !== 1'b0 || result !== 32'd0 || ready_out !== 1'b1)
            $display("FAIL mid_reset got vld=%b res=%h rdy=%b want 0/0/1",
                     valid_out, result, ready_out);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        start_wait(64'sd100, 32'sd7, r, z, lat, ro);
        total++;
        if (r !== 32'd14 || lat !== 65)
            $display("FAIL post_reset_div got %h lat %0d want 0000000e lat 65",
                     r, lat);
        else pass_cnt++;
        release_result();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_saturation();
        test_zero_div();
        test_backpressure();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
